// File: rtl/aline_capture_buffer.sv
// Receive-side A-line capture: stores one A-line of ADC samples after an AFE receive trigger
// and drains it to the UART as high/low byte pairs. Define ALINE_HEADER_EN for a 3-byte drain header.
module aline_capture_buffer #(
    parameter int ADC_W         = 10,
    parameter int NUM_SAMPLES   = 1024,
    parameter int ADDR_W        = 10,
    parameter int BLANK_SAMPLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             afe_switch,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_valid,
    input  logic             tx_busy,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    output logic             mem_clear,
    output logic             capturing,
    output logic             overrun
);

    localparam int RA_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam int BC_W = $clog2(BLANK_SAMPLES + 2);
    localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W+1)'(NUM_SAMPLES);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [BC_W-1:0] BC_ONE    = BC_W'(1);
    localparam logic [BC_W-1:0] BC_LAST   = BC_W'(BLANK_SAMPLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_CAPTURE, S_DRAIN} state_t;
    typedef enum logic [2:0] {P_HDR0, P_HDR1, P_HDR2, P_HI, P_LO} phase_t;

`ifdef ALINE_HEADER_EN
    localparam bit     HDR_EN  = 1'b1;
    localparam phase_t P_FIRST = P_HDR0;
`else
    localparam bit     HDR_EN  = 1'b0;
    localparam phase_t P_FIRST = P_HI;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    phase_t            r_phase;
    logic              r_afe_q;
    logic [BC_W-1:0]   r_blank_cnt;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_rd_addr;
    logic              r_gap;
    logic              r_done;
    logic [7:0]        r_tx_data;
    logic              r_tx_start;
    logic              r_overrun;
    logic [ADC_W-1:0]  r_ram [NUM_SAMPLES];
    logic [ADC_W-1:0]  r_ram_q;
`ifdef ALINE_HEADER_EN
    logic [7:0]        r_aline_idx;
    logic [7:0]        w_hdr_cnt;
    assign w_hdr_cnt = 8'(r_count[ADDR_W-1:0] >> 2);
`endif

    logic       w_trig;
    logic       w_wr_en;
    logic       w_blank_done;
    logic       w_cap_last;
    logic       w_ready;
    logic       w_launch;
    logic       w_finish;
    logic [7:0] w_byte;

    assign w_trig       = afe_switch & ~r_afe_q;
    assign w_wr_en      = (r_state == S_CAPTURE) && afe_switch && adc_valid;
    assign w_blank_done = (r_state == S_BLANK) && afe_switch && adc_valid && (r_blank_cnt == BC_LAST);
    assign w_cap_last   = w_wr_en && ((r_count + CNT_ONE) == COUNT_MAX);
    // One cycle on tx_start plus one gap cycle lets the UART raise tx_busy before we look at it.
    assign w_ready      = !r_tx_start && !r_gap && !tx_busy;
    assign w_launch     = (r_state == S_DRAIN) && !r_done && w_ready;
    assign w_finish     = (r_state == S_DRAIN) && r_done && w_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_trig) w_state_nxt = (BLANK_SAMPLES == 0) ? S_CAPTURE : S_BLANK;
            S_BLANK: begin
                if (!afe_switch)       w_state_nxt = S_IDLE;
                else if (w_blank_done) w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (!afe_switch)     w_state_nxt = (r_count == '0 && !HDR_EN) ? S_IDLE : S_DRAIN;
                else if (w_cap_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN:   if (w_finish) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        capturing = (r_state == S_BLANK) || (r_state == S_CAPTURE);
        mem_clear = (r_state == S_IDLE) || w_finish;
        tx_data   = r_tx_data;
        tx_start  = r_tx_start;
        overrun   = r_overrun;
    end

    always_comb begin
        w_byte = r_ram_q[7:0];
        case (r_phase)
`ifdef ALINE_HEADER_EN
            P_HDR0:  w_byte = 8'hA5;
            P_HDR1:  w_byte = r_aline_idx;
            P_HDR2:  w_byte = w_hdr_cnt;
`endif
            P_HI:    w_byte = 8'(r_ram_q >> 8);
            default: w_byte = r_ram_q[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_afe_q     <= 1'b0;
            r_blank_cnt <= '0;
            r_count     <= '0;
            r_rd_addr   <= '0;
            r_phase     <= P_FIRST;
            r_gap       <= 1'b0;
            r_done      <= 1'b0;
            r_tx_data   <= '0;
            r_tx_start  <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef ALINE_HEADER_EN
            r_aline_idx <= '0;
`endif
        end else begin
            r_afe_q    <= afe_switch;
            r_tx_start <= 1'b0;
            r_gap      <= r_tx_start;
            if (w_trig && r_state != S_IDLE) r_overrun <= 1'b1;
            if (r_state == S_IDLE && w_trig) begin
                r_count     <= '0;
                r_blank_cnt <= '0;
            end
            if (r_state == S_BLANK && afe_switch && adc_valid) r_blank_cnt <= r_blank_cnt + BC_ONE;
            if (w_wr_en) r_count <= r_count + CNT_ONE;
            // Entry gap covers the first RAM read before the high byte is formed.
            if (r_state != S_DRAIN && w_state_nxt == S_DRAIN) begin
                r_rd_addr <= '0;
                r_gap     <= 1'b1;
                r_done    <= 1'b0;
                r_phase   <= P_FIRST;
            end
            if (w_launch) begin
                r_tx_start <= 1'b1;
                r_tx_data  <= w_byte;
                case (r_phase)
`ifdef ALINE_HEADER_EN
                    P_HDR0: r_phase <= P_HDR1;
                    P_HDR1: r_phase <= P_HDR2;
                    P_HDR2: begin
                        if (r_count == '0) r_done  <= 1'b1;
                        else               r_phase <= P_HI;
                    end
`endif
                    P_HI:   r_phase <= P_LO;
                    default: begin
                        r_rd_addr <= r_rd_addr + CNT_ONE;
                        if ((r_rd_addr + CNT_ONE) == r_count) r_done  <= 1'b1;
                        else                                  r_phase <= P_HI;
                    end
                endcase
            end
            if (w_finish) begin
                r_count <= '0;
`ifdef ALINE_HEADER_EN
                r_aline_idx <= r_aline_idx + 8'd1;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_ram[r_count[RA_W-1:0]] <= adc_data;
        r_ram_q <= r_ram[r_rd_addr[RA_W-1:0]];
    end

endmodule

// File: doc/aline_capture_buffer.md
Name: aline_capture_buffer

Overview:
- Receive-side stage downstream of the A-line transmit path.
- When the AFE switch flips to receive, the block records one A-line of ADC echo samples into an on-chip RAM, then drains the RAM byte-wise to the UART transmitter.
- `mem_clear` is driven high once the buffer is empty; the image transmit FSM gates its next A-line on that level.

Parameters:
- ADC_W, 10, ADC sample width; legal range 9..16.
- NUM_SAMPLES, 1024, maximum samples stored per A-line.
- ADDR_W, 10, RAM address width; must satisfy 2**ADDR_W >= NUM_SAMPLES.
- BLANK_SAMPLES, 16, valid samples discarded after trigger (ring-down blanking); 0 disables blanking.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- afe_switch, input, 1, 1 = AFE in receive path; a rising edge triggers capture.
- adc_data, input, ADC_W, ADC sample.
- adc_valid, input, 1, adc_data qualifier, one cycle per sample.
- tx_busy, input, 1, UART transmitter busy.
- tx_data, output, 8, byte to UART; held stable while tx_start is high.
- tx_start, output, 1, one-cycle send request.
- mem_clear, output, 1, 1 = buffer empty and idle.
- capturing, output, 1, 1 while in BLANK or CAPTURE.
- overrun, output, 1, sticky: a trigger arrived while the block was busy.

Behaviour:
- Reset and clocking: reset is rst, synchronous, active-high; clock is clk; all logic is posedge clk only.
- Reset values: state=IDLE, tx_data=0, tx_start=0, mem_clear=1, capturing=0, overrun=0, counters=0.
  - rst mid-capture or mid-drain aborts immediately; RAM contents are discarded logically (count=0).
- Edge detect: afe_switch is registered once; trig = afe_switch & ~afe_switch_q.
- IDLE:
  - mem_clear=1.
  - On trig: go to BLANK (or directly to CAPTURE if BLANK_SAMPLES=0); clear wr_addr and blank_cnt; mem_clear=0 from the next cycle.
- BLANK:
  - Count adc_valid pulses.
  - After BLANK_SAMPLES pulses, go to CAPTURE; the next valid sample is stored at address 0.
- CAPTURE:
  - Each adc_valid writes adc_data to RAM[wr_addr], then wr_addr++.
  - Leave after NUM_SAMPLES writes, or when afe_switch is sampled low (early end).
  - count = number of samples written, 0..NUM_SAMPLES.
  - Go to DRAIN, or to IDLE if count=0.
  - Samples arriving in the same cycle afe_switch is sampled low are not stored.
- BLANK with afe_switch low: go to IDLE with count=0; no bytes are sent.
- DRAIN:
  - RAM is synchronous read, latency 1.
  - For rd_addr 0..count-1, send a high byte then a low byte per sample.
  - High byte = sample[ADC_W-1:8], zero-extended to 8 bits. Low byte = sample[7:0].
- UART handshake:
  - tx_start pulses for exactly one cycle, only when tx_busy=0.
  - After a pulse, wait one cycle (the UART raises tx_busy), then wait for tx_busy=0 before the next byte.
  - tx_data changes only in the cycle tx_start is asserted and holds until the next byte.
- After the last byte is accepted and tx_busy=0, return to IDLE; mem_clear=1 in that same cycle.
- Overrun: a trig in any state other than IDLE sets overrun=1 and is otherwise ignored; overrun is cleared only by rst.
- RAM: inferred NUM_SAMPLES x ADC_W, single write port, single read port; no read-during-write case arises, since states are exclusive.

Optional Feature:
- Macro: ALINE_HEADER_EN.
- Defined:
  - Each drain is prefixed by three bytes: 0xA5, aline_idx, count[ADDR_W-1:2] truncated to 8 bits.
  - aline_idx is an 8-bit counter, reset 0, incremented after each completed drain, wraps 255->0.
  - A drain with count=0 still sends the header, then goes to IDLE.
- Undefined: no header is sent, no aline_idx register exists, and the count=0 path goes straight to IDLE with no bytes sent.

Test Plan:
- Reset/idle: NUM_SAMPLES=4, BLANK_SAMPLES=2. Assert rst 3 cycles -> mem_clear=1, tx_start=0, capturing=0, overrun=0.
- Full capture: raise afe_switch; adc_valid with data 0x3FF, 0x001, 0x155, 0x2AA, 0x0F0, 0x10F; UART model busy 5 cycles per byte.
  - First two samples are blanked.
  - Bytes sent are 01 55, 02 AA, 00 F0, 01 0F.
  - mem_clear=0 throughout; mem_clear=1 after the final tx_busy fall.
- Early end: trigger, blank 2, send samples 0x123 and 0x045, drop afe_switch.
  - Exactly bytes 01 23 00 45 are sent; no extra bytes.
- Blank abort: trigger, drop afe_switch after 1 valid -> no tx_start pulse; mem_clear returns to 1 within 2 cycles.
- Overrun and handshake: retrigger afe_switch during DRAIN -> overrun=1 and stays 1.
  - Drain output is unaltered.
  - Holding tx_busy=1 for 100 cycles stalls output, and tx_start stays 0 meanwhile.
- Header (ALINE_HEADER_EN): two back-to-back full captures.
  - First stream begins A5 00 01.
  - Second stream begins A5 01 01.
  - Mid-drain rst -> outputs at reset values next cycle, and aline_idx=0.
